// File: rtl/mac_prime2r_if.sv
// ---------------------------------------------------------------------------
// mac_prime2r_if
// Handshake bundle for the mac_prime2r frame multiply-accumulate block.
//
// Signals:
//   in_valid  - operand pair present (master -> slave)
//   in_ready  - slave accepts the operand pair this cycle (slave -> master)
//   in_last   - pair is the final term of its frame (master -> slave)
//   a, b      - 24-bit unsigned operands (master -> slave)
//   out_valid - c holds a completed frame sum (slave -> master)
//   out_ready - downstream consumes c (master -> slave)
//   c         - 70-bit unreduced frame sum (slave -> master)
//   err       - sticky frame-length error (slave -> master)
//
// Modports:
//   slave  - the MAC block itself
//   master - the environment that feeds operands and consumes sums
// ---------------------------------------------------------------------------
interface mac_prime2r_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [23:0] a;
  logic [23:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [69:0] c;
  logic        err;

  modport slave (
    input  in_valid, in_last, a, b, out_ready,
    output in_ready, out_valid, c, err
  );

  modport master (
    output in_valid, in_last, a, b, out_ready,
    input  in_ready, out_valid, c, err
  );
endinterface : mac_prime2r_if

// File: rtl/mac_prime2r.sv
// ---------------------------------------------------------------------------
// mac_prime2r
// Multiply-accumulate front end for the 2^24-63 pseudo-Mersenne datapath.
// Operand pairs are multiplied in stage 1 (48-bit product) and summed into a
// 70-bit accumulator in stage 2. The final term of each frame loads the
// unreduced sum into the output register c, which feeds the reducer.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - mac_prime2r_if.slave (in_valid/in_ready/in_last/a/b,
//           out_valid/out_ready/c, err)
//
// Parameters:
//   MAX_TERMS - maximum products per frame (up to 2^22 cannot overflow c)
//   CNT_W     - term counter width, 2^CNT_W must exceed MAX_TERMS
//
// Build option:
//   MAC_TERM_CHECK_EN - when defined, a term counter flags frames longer
//                       than MAX_TERMS on the sticky err output; otherwise
//                       err is tied low and no counter exists.
// ---------------------------------------------------------------------------
module mac_prime2r #(
  parameter int MAX_TERMS = 1024,
  parameter int CNT_W     = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  mac_prime2r_if.slave bus
);

  // Elaboration-time guard: the counter must be able to hold MAX_TERMS.
  if ((2 ** CNT_W) <= MAX_TERMS) begin : g_cnt_w_check
    $error("mac_prime2r: CNT_W too narrow for MAX_TERMS");
  end

  logic        stall_s;
  logic        in_xfer_s;
  logic        s2_fire_s;
  logic        load_c_s;
  logic [47:0] prod_s;
  logic [69:0] sum_s;

  logic [47:0] p1_r;
  logic        l1_r;
  logic        v1_r;
  logic [69:0] acc_r;
  logic [69:0] c_r;
  logic        out_valid_r;

  // Handshake decode and datapath arithmetic.
  // A stall only happens when a last term waits for an occupied output
  // register; non-last terms can always drain into the accumulator.
  always_comb begin
    stall_s   = v1_r & l1_r & out_valid_r & ~bus.out_ready;
    in_xfer_s = bus.in_valid & ~stall_s;
    s2_fire_s = v1_r & ~stall_s;
    load_c_s  = s2_fire_s & l1_r;
    prod_s    = {24'd0, bus.a} * {24'd0, bus.b};
    sum_s     = acc_r + {22'd0, p1_r};
  end

  assign bus.in_ready  = ~stall_s;
  assign bus.out_valid = out_valid_r;
  assign bus.c         = c_r;

  // Stage 1: product register; holds its contents while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_r <= 48'd0;
      l1_r <= 1'b0;
      v1_r <= 1'b0;
    end else if (!stall_s) begin
      v1_r <= in_xfer_s;
      if (in_xfer_s) begin
        p1_r <= prod_s;
        l1_r <= bus.in_last;
      end
    end
  end

  // Stage 2: accumulator and output register.
  // out_valid drops on a transfer unless a new last term reloads c in the
  // same cycle; c only changes on a load, so it is stable while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= 70'd0;
      c_r         <= 70'd0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= load_c_s | (out_valid_r & ~bus.out_ready);
      if (load_c_s) begin
        c_r <= sum_s;
      end
      if (s2_fire_s) begin
        acc_r <= load_c_s ? 70'd0 : sum_s;
      end
    end
  end

`ifdef MAC_TERM_CHECK_EN
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_TERMS - 1);
  localparam logic [CNT_W-1:0] SAT_CNT  = CNT_W'(MAX_TERMS);

  logic [CNT_W-1:0] cnt_r;
  logic             err_r;

  // Term counter and sticky overlength flag. The count saturates at
  // MAX_TERMS so an arbitrarily long frame cannot wrap it back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
      err_r <= 1'b0;
    end else if (in_xfer_s) begin
      if (bus.in_last) begin
        cnt_r <= '0;
      end else begin
        if (cnt_r == LAST_CNT) begin
          err_r <= 1'b1;
        end
        if (cnt_r != SAT_CNT) begin
          cnt_r <= cnt_r + 1'b1;
        end
      end
    end
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

endmodule : mac_prime2r

// File: tb/tb_mac_prime2r.sv
// ---------------------------------------------------------------------------
// tb_mac_prime2r
// Directed self-checking bench for mac_prime2r: reset state, pipeline
// latency, multi-term frames, maximum operands, output back-pressure with a
// queued term, mid-frame reset and (when MAC_TERM_CHECK_EN is defined) the
// overlength error flag.
// ---------------------------------------------------------------------------
module tb_mac_prime2r;

`ifdef MAC_TERM_CHECK_EN
  localparam int TB_MAX_TERMS = 4;
`else
  localparam int TB_MAX_TERMS = 1024;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  mac_prime2r_if bus ();

  mac_prime2r #(
    .MAX_TERMS (TB_MAX_TERMS),
    .CNT_W     (11)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [23:0] av, input logic [23:0] bv, input logic last);
    bus.in_valid = v;
    bus.a        = av;
    bus.b        = bv;
    bus.in_last  = last;
  endtask

  initial begin
    n_checks      = 0;
    n_fails       = 0;
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 24'd0, 24'd0, 1'b0);
    tick();
    tick();
    check("reset_in_ready", 70'(bus.in_ready), 70'd1);
    check("reset_out_valid", 70'(bus.out_valid), 70'd0);
    check("reset_c", bus.c, 70'd0);
    check("reset_err", 70'(bus.err), 70'd0);
    rst_n = 1'b1;
    tick();

    // Single term 3*5: valid two edges after presentation.
    drive(1'b1, 24'd3, 24'd5, 1'b1);
    tick();
    drive(1'b0, 24'd0, 24'd0, 1'b0);
    check("single_lat1_out_valid", 70'(bus.out_valid), 70'd0);
    tick();
    check("single_out_valid", 70'(bus.out_valid), 70'd1);
    check("single_c", bus.c, 70'd15);
    tick();
    check("single_drained", 70'(bus.out_valid), 70'd0);

    // Three-term frame 2*3 + 4*5 + 6*7 = 68.
    drive(1'b1, 24'd2, 24'd3, 1'b0);
    tick();
    drive(1'b1, 24'd4, 24'd5, 1'b0);
    tick();
    drive(1'b1, 24'd6, 24'd7, 1'b1);
    tick();
    drive(1'b0, 24'd0, 24'd0, 1'b0);
    check("frame3_pending", 70'(bus.out_valid), 70'd0);
    tick();
    check("frame3_out_valid", 70'(bus.out_valid), 70'd1);
    check("frame3_c", bus.c, 70'd68);
    tick();

    // Maximum operands (p-1)^2.
    drive(1'b1, 24'd16777152, 24'd16777152, 1'b1);
    tick();
    drive(1'b0, 24'd0, 24'd0, 1'b0);
    tick();
    check("max_c", bus.c, 70'd281472829231104);
    check("max_out_valid", 70'(bus.out_valid), 70'd1);
    tick();

    // Back-pressure: frame A (68) held, frame B (5*5 + 3*3 = 34) stalls in
    // stage 1, and a single-term frame C (7*1) waits at the input.
    bus.out_ready = 1'b0;
    drive(1'b1, 24'd2, 24'd3, 1'b0);
    tick();
    drive(1'b1, 24'd4, 24'd5, 1'b0);
    tick();
    drive(1'b1, 24'd6, 24'd7, 1'b1);
    tick();
    drive(1'b1, 24'd5, 24'd5, 1'b0);
    tick();
    check("bp_a_out_valid", 70'(bus.out_valid), 70'd1);
    check("bp_a_c", bus.c, 70'd68);
    drive(1'b1, 24'd3, 24'd3, 1'b1);
    tick();
    drive(1'b1, 24'd7, 24'd1, 1'b1);
    check("bp_stall_in_ready", 70'(bus.in_ready), 70'd0);
    check("bp_stall_c", bus.c, 70'd68);
    tick();
    check("bp_stall_hold_c", bus.c, 70'd68);
    check("bp_stall_hold_in_ready", 70'(bus.in_ready), 70'd0);
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 70'(bus.in_ready), 70'd1);
    tick();
    drive(1'b0, 24'd0, 24'd0, 1'b0);
    check("bp_b_out_valid", 70'(bus.out_valid), 70'd1);
    check("bp_b_c", bus.c, 70'd34);
    tick();
    check("bp_c_out_valid", 70'(bus.out_valid), 70'd1);
    check("bp_c_c", bus.c, 70'd7);
    tick();
    check("bp_drained", 70'(bus.out_valid), 70'd0);

    // Mid-frame reset with a held output (81) and a partial sum pending.
    bus.out_ready = 1'b0;
    drive(1'b1, 24'd9, 24'd9, 1'b1);
    tick();
    drive(1'b1, 24'd2, 24'd3, 1'b0);
    tick();
    drive(1'b1, 24'd4, 24'd5, 1'b0);
    tick();
    drive(1'b0, 24'd0, 24'd0, 1'b0);
    check("prerst_c", bus.c, 70'd81);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 70'(bus.out_valid), 70'd0);
    check("midrst_c", bus.c, 70'd0);
    check("midrst_in_ready", 70'(bus.in_ready), 70'd1);
    tick();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    drive(1'b1, 24'd7, 24'd7, 1'b1);
    tick();
    drive(1'b0, 24'd0, 24'd0, 1'b0);
    tick();
    check("postrst_out_valid", 70'(bus.out_valid), 70'd1);
    check("postrst_c", bus.c, 70'd49);
    tick();

`ifdef MAC_TERM_CHECK_EN
    // Five-term frame of 1*1 with MAX_TERMS=4: err rises on the 4th
    // non-last term, the sum is still 5, and err stays set afterwards.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 24'd1, 24'd1, (i == 4));
      tick();
      if (i == 2) check("err_before_limit", 70'(bus.err), 70'd0);
      if (i == 3) check("err_at_limit", 70'(bus.err), 70'd1);
    end
    drive(1'b0, 24'd0, 24'd0, 1'b0);
    tick();
    check("err_frame_c", bus.c, 70'd5);
    tick();
    drive(1'b1, 24'd2, 24'd2, 1'b1);
    tick();
    drive(1'b0, 24'd0, 24'd0, 1'b0);
    tick();
    check("err_next_c", bus.c, 70'd4);
    check("err_sticky", 70'(bus.err), 70'd1);
`else
    // Long frame without the term check: err must stay low.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 24'd1, 24'd1, (i == 5));
      tick();
    end
    drive(1'b0, 24'd0, 24'd0, 1'b0);
    tick();
    check("noerr_frame_c", bus.c, 70'd6);
    check("noerr_err", 70'(bus.err), 70'd0);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_mac_prime2r
